// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one single-port word memory between
// instruction fetch (read-only port I) and load/store (read/write port D).
// One transaction at a time: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// All outputs are registered; a WAIT that sees no mem_done for TIMEOUT cycles
// ends with err=1 and rdata=0.
module mem_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_done,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wmask,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        d_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    output logic        mem_wstrobe,
    output logic        mem_rstrobe,
    input  logic [31:0] mem_rdata,
    input  logic        mem_done,
    output logic        grant,
    output logic        busy
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state;
    logic          we_q;     // latched direction of the current transaction
    logic          last_d;   // last completed owner was D
    logic [CW-1:0] cnt;      // WAIT cycles without mem_done
    logic          pick_d;

    // D wins when it is the only requester, or on a tie when I was served last
    assign pick_d = d_req & (~i_req | ~last_d);

    // Arbitration FSM; every output is a register updated on state transitions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            we_q        <= 1'b0;
            last_d      <= 1'b1;
            cnt         <= '0;
            i_rdata     <= '0;
            i_done      <= 1'b0;
            i_err       <= 1'b0;
            d_rdata     <= '0;
            d_done      <= 1'b0;
            d_err       <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_wmask   <= '0;
            mem_wstrobe <= 1'b0;
            mem_rstrobe <= 1'b0;
            grant       <= 1'b0;
            busy        <= 1'b0;
        end else begin
            // pulses and strobes last a single cycle unless set below
            i_done      <= 1'b0;
            i_err       <= 1'b0;
            d_done      <= 1'b0;
            d_err       <= 1'b0;
            mem_wstrobe <= 1'b0;
            mem_rstrobe <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        grant <= pick_d;
                        busy  <= 1'b1;
                        state <= ISSUE;
                        if (pick_d) begin
                            mem_addr    <= d_addr;
                            mem_wdata   <= d_wdata;
                            mem_wmask   <= d_wmask;
                            we_q        <= d_we;
                            mem_wstrobe <= d_we;
                            mem_rstrobe <= ~d_we;
                        end else begin
                            mem_addr    <= i_addr;
                            mem_wdata   <= '0;
                            mem_wmask   <= '0;
                            we_q        <= 1'b0;
                            mem_rstrobe <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (mem_done || cnt == CW'(TIMEOUT - 1)) begin
                        state <= RESP;
                        if (grant) begin
                            d_done  <= 1'b1;
                            d_err   <= ~mem_done;
                            d_rdata <= (mem_done && !we_q) ? mem_rdata : 32'h0;
                        end else begin
                            i_done  <= 1'b1;
                            i_err   <= ~mem_done;
                            i_rdata <= mem_done ? mem_rdata : 32'h0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    last_d <= grant;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one single-port synchronous word memory between two requesters: instruction fetch (port I, read-only) and load/store (port D, read/write). Grants one transaction at a time with round-robin fairness and drives the memory's strobe/address/data bus. Holds the address until completion, returns read data to the owner, and flags hung transactions via a timeout. Sits between the core's fetch/LSU and the memory block.

Parameters:
TIMEOUT, 16, WAIT cycles without mem_done before the transaction is aborted with error; must be >= 1.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i_req  in  1  fetch request; held with i_addr until i_done
i_addr  in  32  fetch byte address
i_rdata  out  32  fetch read data, valid while i_done=1
i_done  out  1  one-cycle completion pulse, fetch
i_err  out  1  qualifies i_done: timeout occurred
d_req  in  1  data request; held with d_* until d_done
d_we  in  1  1 = write, 0 = read
d_addr  in  32  data byte address
d_wdata  in  32  write data
d_wmask  in  4  byte-lane write enables
d_rdata  out  32  data read data, valid while d_done=1
d_done  out  1  one-cycle completion pulse, data
d_err  out  1  qualifies d_done: timeout occurred
mem_addr  out  32  memory address
mem_wdata  out  32  memory write data
mem_wmask  out  4  memory byte mask
mem_wstrobe  out  1  memory write strobe
mem_rstrobe  out  1  memory read strobe
mem_rdata  in  32  memory read data
mem_done  in  1  memory completion indication
grant  out  1  current/last owner: 0 = I, 1 = D
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0 (rdata, done, err, mem_* buses, strobes, grant, busy); timeout counter 0; last-grant = D, so I wins the first tie.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: requests are sampled only here. If exactly one req is high, grant it. If both are high, grant the port not granted last (round-robin). Latch the owner's addr/wdata/wmask/we into registers; port I is always a read with wmask 0. Set grant. Next state ISSUE. With no req, stay in IDLE.
- ISSUE (exactly 1 cycle): mem_rstrobe=1 for a read or mem_wstrobe=1 for a write; mem_addr/wdata/wmask carry the latched values. Clear the counter. Next state WAIT.
- WAIT: strobes 0; mem_addr/wdata/wmask held stable.
  - If mem_done=1: capture mem_rdata (reads only; writes return 0) and go to RESP with err=0.
  - Else increment the counter. When the counter reaches TIMEOUT, go to RESP with err=1 and rdata 0.
- RESP (1 cycle): the owner's done=1, its rdata valid, err as determined. The non-owner's done stays 0. Record last-grant. Next state IDLE.
- Latency: a request sampled in IDLE at cycle N gives ISSUE at N+1, WAIT at N+2, and done at N+3 when mem_done is high at N+2. Minimum back-to-back rate is one transaction per 4 cycles.
- The requester must drop or refresh req in the cycle done is seen. A still-high req in the following IDLE cycle is treated as a new request.
- A req that drops mid-transaction does not abort it; done is still pulsed.
- Address, mask and data changes after grant are ignored (latched copies are used).
- mem_done is sampled only in WAIT; its value in other states is ignored.
- rdata outputs hold their last value after done falls; only done qualifies them.
- Reset mid-transaction: immediate return to IDLE, strobes 0, no done pulse.
- Both strobes are never high together; at most one strobe is high per transaction.

Test Plan:
- Single fetch: i_req=1, i_addr=0x10, memory word 4 = 0xDEADBEEF, mem_done in WAIT -> mem_rstrobe high exactly 1 cycle with mem_addr=0x10; i_done pulse at N+3 with i_rdata=0xDEADBEEF, i_err=0, d_done=0.
- Masked write then read: d_we=1, d_addr=0x8, d_wdata=0x11223344, d_wmask=4'b0101 -> mem_wstrobe 1 cycle with mask 0101 and d_done=1. A following read of 0x8 over previous contents 0 -> d_rdata=0x00220044.
- Contention: i_req and d_req both high continuously from reset -> grants alternate I, D, I, D. Each done pulses only for its owner; no strobe overlap.
- Timeout: TIMEOUT=16, mem_done held 0 -> d_done and d_err high 17 cycles after ISSUE, d_rdata=0; the arbiter returns to IDLE and serves the next request normally.
- Stability: d_addr changed from 0x20 to 0x40 during WAIT -> mem_addr stays 0x20 until RESP.
- Async reset: assert rst_n=0 in WAIT -> busy, strobes and done go 0 immediately without clk; after release, the first tie is granted to I.
